fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/ca_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ca_pkg.sv
// ca_pkg: shared opcode constants, NOP encoding, fetch FSM states and buffer entry type
package ca_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction buffer with flush; a push into a full buffer is taken only alongside a pop
module fetch_fifo
    import ca_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_wdata,
    output fetch_entry_t o_rdata,
    output logic         o_full,
    output logic         o_empty,
    output logic [AW:0]  o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // storage write; no reset needed, occupancy tracking decides what is valid
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

    // pointers and occupancy; flush wins over any same-cycle push/pop
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= w_push ? r_wptr + 1'b1 : r_wptr;
            r_rptr  <= w_pop ? r_rptr + 1'b1 : r_rptr;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect and buffered output (optional FETCH_MISALIGN_CHECK_EN)
module fetch_unit
    import ca_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        arst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode,
    output logic        fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_pc;
    logic         r_discard;
    logic         w_fault;
    logic         w_bad;
    logic [31:0]  w_rpc;
    logic         w_redir;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_cnt_next;
    fetch_entry_t w_head;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_fault;
    assign w_bad   = redirect && !r_fault && (redirect_pc[1:0] != 2'b00);
    assign w_rpc   = redirect_pc;
    assign w_fault = r_fault;

    // sticky misalignment fault, cleared only by reset
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_fault <= 1'b0;
        else         r_fault <= r_fault | w_bad;
    end
`else
    assign w_bad   = 1'b0;
    assign w_rpc   = redirect_pc & ~32'h3;
    assign w_fault = 1'b0;
`endif

    assign w_redir    = redirect && !w_fault && !w_bad;
    assign w_pop      = instr_valid && instr_ready;
    assign w_push     = (r_state == WAIT) && imem_rvalid && !r_discard && !redirect;
    assign w_cnt_next = w_count + CW'(w_push) - CW'(w_pop);

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect && !w_fault),
        .i_wdata ({r_req_pc, imem_rdata}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign imem_req    = r_state == REQ;
    assign imem_addr   = r_pc;
    assign instr_valid = !w_empty;
    assign instr       = w_empty ? NOP_INSTR : w_head.instr;
    assign instr_pc    = w_empty ? 32'h0 : w_head.pc;
    assign opcode      = instr[6:0];
    assign fetch_fault = w_fault;

    // fetch FSM: redirect outranks everything, misaligned redirect parks the unit in IDLE
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_req_pc  <= RESET_PC;
            r_discard <= 1'b0;
        end else if (w_bad) begin
            r_state   <= IDLE;
            r_discard <= 1'b0;
        end else if (w_redir) begin
            r_pc <= w_rpc;
            case (r_state)
                REQ: begin
                    r_state   <= WAIT;
                    r_discard <= 1'b1;
                end
                WAIT: begin
                    r_state   <= imem_rvalid ? REQ : WAIT;
                    r_discard <= !imem_rvalid;
                end
                default: begin
                    r_state   <= REQ;
                    r_discard <= 1'b0;
                end
            endcase
        end else begin
            case (r_state)
                IDLE: r_state <= w_fault ? IDLE : REQ;
                REQ: begin
                    r_req_pc <= r_pc;
                    r_pc     <= r_pc + 32'd4;
                    r_state  <= WAIT;
                end
                WAIT: if (imem_rvalid) begin
                    r_discard <= 1'b0;
                    r_state   <= (w_cnt_next != CW'(FIFO_DEPTH)) ? REQ : HOLD;
                end
                default: r_state <= w_full ? HOLD : REQ;
            endcase
        end
    end

endmodule
